// File: rtl/dac_serial_tx_fil.sv
// dac_serial_tx_fil
// Output end of the filter datapath. Takes one (L+1)-bit filter result per
// valid/ready transfer and shifts it out MSB first to an external DAC over a
// mode-0 SPI-like link (cs_n, sclk, sdo).
//
// Ports
//   clk       system clock, all logic on its rising edge
//   rst       asynchronous, active-low reset
//   in_data   filter sample to transmit (L+1 bits)
//   in_valid  in_data valid
//   in_ready  block can accept a word (high in IDLE only)
//   cs_n      DAC chip select, active low
//   sclk      serial clock, each half-period lasts DIV clk cycles
//   sdo       serial data, changes only while sclk = 0
//   done      one-cycle pulse at the end of each frame
module dac_serial_tx_fil #(
    parameter int L   = 24,
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [L:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cs_n,
    output logic       sclk,
    output logic       sdo,
    output logic       done
);

    localparam int BW = $clog2(L + 2);
    localparam int HW = $clog2(DIV + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(L);
    localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [L:0]      shreg_reg, shreg_next;
    logic [BW-1:0]   bit_reg, bit_next;
    logic [HW-1:0]   half_reg, half_next;
    logic            sclk_reg, sclk_next;
    logic            cs_n_reg, cs_n_next;
    logic            done_reg, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            bit_reg   <= '0;
            half_reg  <= '0;
            sclk_reg  <= 1'b0;
            cs_n_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            bit_reg   <= bit_next;
            half_reg  <= half_next;
            sclk_reg  <= sclk_next;
            cs_n_reg  <= cs_n_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        bit_next   = bit_reg;
        half_next  = half_reg;
        sclk_next  = sclk_reg;
        cs_n_next  = cs_n_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                    shreg_next = in_data;
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    bit_next   = '0;
                    half_next  = '0;
                end
            end
            SHIFT: begin
                if (half_reg == HALF_LAST) begin
                    half_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == BIT_LAST) begin
                            // Last high phase over: close the frame. Clearing
                            // the shift register also forces sdo low.
                            state_next = GAP;
                            cs_n_next  = 1'b1;
                            shreg_next = '0;
                            bit_next   = '0;
                            done_next  = 1'b1;
                        end else begin
                            // Falling sclk edge: present the next lower bit.
                            bit_next   = bit_reg + BW'(1);
                            shreg_next = {shreg_reg[L-1:0], 1'b0};
                        end
                    end
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
            GAP: begin
                if (half_reg == HALF_LAST) begin
                    state_next = IDLE;
                    half_next  = '0;
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All serial outputs come straight from flops so the DAC sees no glitches.
    assign in_ready = (state_reg == IDLE);
    assign cs_n     = cs_n_reg;
    assign sclk     = sclk_reg;
    assign sdo      = shreg_reg[L];
    assign done     = done_reg;

endmodule

// File: tb/tb_dac_serial_tx_fil.sv
module tb_dac_serial_tx_fil;

    localparam int L = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [L:0]  din [2];
    logic        vld [2];
    logic        rdy [2];
    logic        csn [2];
    logic        sck [2];
    logic        sdo_w [2];
    logic        dn  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_serial_tx_fil #(.L(L), .DIV(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .cs_n(csn[0]), .sclk(sck[0]), .sdo(sdo_w[0]), .done(dn[0])
    );

    dac_serial_tx_fil #(.L(L), .DIV(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .cs_n(csn[1]), .sclk(sck[1]), .sdo(sdo_w[1]), .done(dn[1])
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at t=%0t", nm, idx, act_v, exp_v, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // ---------------- behavioural model ----------------
    // A frame is described only by its acceptance edge and word; every output
    // is then a closed-form function of the number of edges since acceptance.
    int          edge_cnt = 0;
    bit          act [2];
    int          t0  [2];
    logic [L:0]  mw  [2];

    always @(posedge clk) begin
        edge_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                act[i] = 1'b0;
            end else if ((!act[i] || (edge_cnt - 1 - t0[i]) >= 2*div_of(i)*(L+1) + div_of(i)) && vld[i]) begin
                act[i] = 1'b1;
                t0[i]  = edge_cnt;
                mw[i]  = din[i];
            end
        end
    end

    // ---------------- compare process + serial receiver ----------------
    logic [L:0]  exp_q0 [$];
    logic [L:0]  exp_q1 [$];
    logic [L:0]  rx      [2];
    int          nb      [2] = '{0, 0};
    logic        psck    [2] = '{1'b0, 1'b0};
    int          done_cnt[2] = '{0, 0};
    int          done_edge[2] = '{0, 0};
    int          low_run [2] = '{0, 0};
    int          last_low[2] = '{0, 0};
    int          hi_run  [2] = '{0, 0};
    int          last_gap[2] = '{0, 0};

    always @(negedge clk) begin
        int dv, fr, d;
        logic e_cs, e_sck, e_sdo, e_dn, e_rdy;
        logic [L:0] ew;
        for (int i = 0; i < 2; i++) begin
            dv = div_of(i);
            fr = 2 * dv * (L + 1);
            e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_dn = 1'b0; e_rdy = 1'b1;
            if (!rst) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                d = edge_cnt - t0[i];
                if (d < fr) begin
                    e_cs  = 1'b0;
                    e_sck = ((d / dv) % 2) == 1;
                    e_sdo = mw[i][L - d / (2 * dv)];
                    e_rdy = 1'b0;
                end else begin
                    e_dn  = (d == fr);
                    e_rdy = (d >= fr + dv);
                end
            end
            chk("cs_n",     i, 32'(csn[i]),   32'(e_cs));
            chk("sclk",     i, 32'(sck[i]),   32'(e_sck));
            chk("sdo",      i, 32'(sdo_w[i]), 32'(e_sdo));
            chk("done",     i, 32'(dn[i]),    32'(e_dn));
            chk("in_ready", i, 32'(rdy[i]),   32'(e_rdy));

            // Receiver: DAC samples sdo on sclk rising edges.
            if (!rst) begin
                nb[i] = 0;
                rx[i] = '0;
                low_run[i] = 0;
            end else begin
                if (sck[i] && !psck[i]) begin
                    rx[i] = {rx[i][L-1:0], sdo_w[i]};
                    nb[i]++;
                end
                if (csn[i] == 1'b0) begin
                    low_run[i]++;
                    if (hi_run[i] != 0) last_gap[i] = hi_run[i];
                    hi_run[i] = 0;
                end else begin
                    hi_run[i]++;
                    if (low_run[i] != 0) last_low[i] = low_run[i];
                    low_run[i] = 0;
                end
                if (dn[i]) begin
                    done_cnt[i]++;
                    done_edge[i] = edge_cnt;
                    chk("rx_bits", i, 32'(nb[i]), 32'(L + 1));
                    if (i == 0 && exp_q0.size() > 0) begin
                        ew = exp_q0.pop_front();
                        chk("rx_word", i, 32'(rx[i]), 32'(ew));
                    end else if (i == 1 && exp_q1.size() > 0) begin
                        ew = exp_q1.pop_front();
                        chk("rx_word", i, 32'(rx[i]), 32'(ew));
                    end else begin
                        chk("rx_unexpected_frame", i, 32'd1, 32'd0);
                    end
                    nb[i] = 0;
                end
            end
            psck[i] = sck[i];
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int acc;
    int rcnt;

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            vld[i] = 1'b0;
        end
        step(3);
        rst = 1'b1;
        step(2);

        // Single frame, DIV = 2.
        exp_q0.push_back(25'h1ABCDEF);
        din[0] = 25'h1ABCDEF; vld[0] = 1'b1;
        step(1);
        acc = edge_cnt;
        vld[0] = 1'b0;
        step(110);
        chk("cs_low_cycles", 0, 32'(last_low[0]), 32'd100);
        chk("done_offset",   0, 32'(done_edge[0] - acc), 32'd100);

        // Back-to-back with in_valid held high.
        exp_q0.push_back(25'h0000001);
        exp_q0.push_back(25'h1FFFFFF);
        din[0] = 25'h0000001; vld[0] = 1'b1;
        step(1);
        din[0] = 25'h1FFFFFF;
        rcnt = 0;
        repeat (103) begin
            step(1);
            if (rdy[0]) rcnt++;
        end
        vld[0] = 1'b0;
        chk("ready_cycles_between", 0, 32'(rcnt), 32'd1);
        step(110);
        chk("cs_high_gap", 0, 32'(last_gap[0]), 32'd3);

        // Busy input: data and valid wiggle during the frame.
        exp_q0.push_back(25'h0F0F0F3);
        din[0] = 25'h0F0F0F3; vld[0] = 1'b1;
        step(1);
        repeat (40) begin
            step(1);
            din[0] = '0;
            vld[0] = ~vld[0];
        end
        vld[0] = 1'b0;
        step(70);

        // Reset mid-frame at bit 10, then a full frame.
        din[0] = 25'h155AA33; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        step(42);
        #1 rst = 1'b0;
        #1;
        chk("rst_cs_n",     0, 32'(csn[0]),   32'd1);
        chk("rst_sclk",     0, 32'(sck[0]),   32'd0);
        chk("rst_sdo",      0, 32'(sdo_w[0]), 32'd0);
        chk("rst_done",     0, 32'(dn[0]),    32'd0);
        chk("rst_in_ready", 0, 32'(rdy[0]),   32'd1);
        step(3);
        rst = 1'b1;
        step(1);
        exp_q0.push_back(25'h0AAAAAA);
        din[0] = 25'h0AAAAAA; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        step(110);

        // DIV = 1 instance.
        exp_q1.push_back(25'h1555555);
        din[1] = 25'h1555555; vld[1] = 1'b1;
        step(1);
        acc = edge_cnt;
        vld[1] = 1'b0;
        step(60);
        chk("cs_low_cycles", 1, 32'(last_low[1]), 32'd50);
        chk("done_offset",   1, 32'(done_edge[1] - acc), 32'd50);

        chk("frames_done", 0, 32'(done_cnt[0]), 32'd5);
        chk("frames_done", 1, 32'(done_cnt[1]), 32'd1);
        chk("frames_missing", 0, 32'(exp_q0.size()), 32'd0);
        chk("frames_missing", 1, 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
